alu_seq: RTL and testbench

- Parametrised, handshaked successor of the combinational RV32 ALU.
- Accepts one operation per transaction on a valid/ready input channel and returns a registered result on a valid/ready output channel.
- Also returns the aligned address/offset split and a zero flag.
- Adds OR, SRL, SLT, SLTU, an illegal-op error flag and an optional multi-cycle iterative multiplier.
- Sits between the register-file/immediate operand muxes and the writeback/LSU stage.

---
 rtl/alu_seq.sv | 109 ++++++++++
 tb/tb_alu_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked RV32-style ALU with registered result, address/offset split, zero and error flags
//   Optional macro ALU_SEQ_MUL_EN builds the iterative shift-add MUL (alu_sel=10) and its BUSY state.
//   Ports: clk, rst_n (sync, active-low)
//          in_valid/in_ready + a, b, alu_sel  : operation input channel
//          out_valid/out_ready                 : result output channel
//          result, offset, address, zero, err  : registered result and views derived from it
module alu_seq #(
  parameter int WIDTH      = 32,
  parameter int ALIGN_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [3:0]            alu_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      result,
  output logic [ALIGN_BITS-1:0] offset,
  output logic [WIDTH-1:0]      address,
  output logic                  zero,
  output logic                  err
);
  localparam int SHW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] res_c, mul_res;
  logic [SHW-1:0] sh;
  logic err_c, is_mul, mul_done, accept;
  assign sh = b[SHW-1:0];
  // in_ready is forced low while reset is asserted so nothing is accepted during reset
  assign in_ready  = rst_n && (state == IDLE || (state == DONE && out_ready));
  assign out_valid = state == DONE;
  assign accept    = in_valid && in_ready;
  assign offset    = result[ALIGN_BITS-1:0];
  assign address   = {result[WIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
  assign zero      = result == '0;
  always_comb begin
    res_c = '0;
    err_c = 1'b0;
    case (alu_sel)
      4'd0:  res_c = a + b;
      4'd1:  res_c = a - b;
      4'd2:  res_c = a & b;
      4'd3:  res_c = a ^ b;
      4'd4:  res_c = a << sh;
      4'd5:  res_c = $signed(a) >>> sh;
      4'd6:  res_c = a | b;
      4'd7:  res_c = a >> sh;
      4'd8:  res_c = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'd9:  res_c = {{(WIDTH-1){1'b0}}, a < b};
`ifdef ALU_SEQ_MUL_EN
      4'd10: res_c = '0;
`endif
      default: err_c = 1'b1;
    endcase
  end
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] acc, acc_n, mcand, mplier;
  logic [SHW-1:0] cnt;
  assign is_mul   = alu_sel == 4'd10;
  assign acc_n    = acc + (mplier[0] ? mcand : '0);
  // the last iteration's sum goes straight to result, so DONE follows the WIDTH-th iteration edge
  assign mul_done = cnt == SHW'(WIDTH - 1);
  assign mul_res  = acc_n;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (accept && is_mul) begin
      acc    <= '0;
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (state == BUSY) begin
      acc    <= acc_n;
      cnt    <= cnt + 1'b1;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
`endif
  always_comb begin
    state_n = state;
    if (accept) state_n = is_mul ? BUSY : DONE;
    else if (state == DONE && out_ready) state_n = IDLE;
    else if (state == BUSY && mul_done) state_n = DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) err <= err_c;
      if (accept && !is_mul) result <= res_c;
      else if (state == BUSY && mul_done) result <= mul_res;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with directed cases and randomized traffic
module tb_alu_seq;
  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
    int          acc_cyc;
  } exp_t;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [31:0] a = 0, b = 0;
  logic [3:0]  alu_sel = 0;
  logic        in_ready, out_valid, zero, err;
  logic [31:0] result, address;
  logic [1:0]  offset;
  int cyc = 0, vecs = 0, errs = 0, checks = 0, bp_mode = 0, w, busy_rdy;
  bit seen = 0;
  exp_t q[$];
  logic [31:0] edges[4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  alu_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_sel(alu_sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .offset(offset), .address(address), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // reference: {err, result} straight from the operation definitions
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    int s = int'(y[4:0]);
    case (op)
      0: return {1'b0, x + y};
      1: return {1'b0, x - y};
      2: return {1'b0, x & y};
      3: return {1'b0, x ^ y};
      4: return {1'b0, x << s};
      5: return {1'b0, (x >> s) | (x[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0)};
      6: return {1'b0, x | y};
      7: return {1'b0, x >> s};
      8: return {1'b0, 31'h0, $signed(x) < $signed(y)};
      9: return {1'b0, 31'h0, x < y};
      10: return MUL_ON ? {1'b0, x * y} : {1'b1, 32'h0};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = bp_mode == 0 ? 1'b1 : bp_mode == 2 ? 1'b0 : ($urandom_range(0, 2) != 0);
  end

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_out: got out_valid=1 result %h, expected no output", result);
      end else begin
        chk("result", result, q[0].res);
        chk("err", err, q[0].err);
        chk("zero", zero, q[0].res == 0);
        chk("offset", offset, q[0].res[1:0]);
        chk("address", address, {q[0].res[31:2], 2'b00});
        if (!seen) begin
          chk("latency", cyc - q[0].acc_cyc, q[0].lat);
          seen = 1;
        end
        if (out_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  // called at posedge+2; returns at posedge+2 after the accept edge with in_valid dropped
  task automatic send(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, output int waits);
    exp_t e;
    logic [32:0] m;
    alu_sel = op;
    a = x;
    b = y;
    in_valid = 1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errs++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected accept", waits);
      in_valid = 0;
      return;
    end
    m = model(op, x, y);
    e.res = m[31:0];
    e.err = m[32];
    e.lat = (op == 10 && MUL_ON) ? 33 : 1;
    e.acc_cyc = cyc;
    q.push_back(e);
    vecs++;
    @(posedge clk);
    #2;
    in_valid = 0;
  endtask

  initial begin
    logic [3:0] op;
    logic [31:0] x, y;
    int n;
    rst_n = 0;
    in_valid = 1;
    a = 1;
    b = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_result", result, 0);
      chk("rst_err", err, 0);
    end
    @(posedge clk);
    #2;
    rst_n = 1;
    in_valid = 0;
    send(0, 32'h0000_1003, 32'h0000_0002, w);
    chk("first_accept_wait", w, 0);
    chk("add_result", result, 32'h0000_1005);
    chk("add_offset", offset, 2'b01);
    chk("add_address", address, 32'h0000_1004);
    chk("add_zero", zero, 0);
    send(5, 32'h8000_0000, 32'h0000_0024, w);
    chk("b2b_wait", w, 0);
    chk("sra_result", result, 32'hF800_0000);
    send(8, 32'hFFFF_FFFF, 32'h1, w);
    chk("slt_result", result, 1);
    send(9, 32'hFFFF_FFFF, 32'h1, w);
    chk("sltu_result", result, 0);
    send(1, 5, 5, w);
    chk("sub_result", result, 0);
    chk("sub_zero", zero, 1);
    bp_mode = 2;
    send(0, 1, 1, w);
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_result", result, 2);
    end
    bp_mode = 0;
    send(6, 32'hF0F0_0000, 32'h0000_0F0F, w);
    chk("bp_release_wait", w, 0);
    chk("or_result", result, 32'hF0F0_0F0F);
    send(13, 32'h1234_5678, 32'h9, w);
    chk("illegal_result", result, 0);
    chk("illegal_err", err, 1);
    chk("illegal_zero", zero, 1);
    send(7, 32'h8000_0000, 32'h1F, w);
    chk("err_cleared", err, 0);
    chk("srl_result", result, 1);
`ifdef ALU_SEQ_MUL_EN
    send(10, 32'h0001_0003, 32'h0000_0005, w);
    busy_rdy = 0;
    repeat (32) begin
      @(negedge clk);
      busy_rdy += int'(in_ready) + int'(out_valid);
    end
    chk("mul_busy_flags", busy_rdy, 0);
    @(negedge clk);
    chk("mul_out_valid", out_valid, 1);
    chk("mul_result", result, 32'h0005_000F);
    @(posedge clk);
    #2;
    send(10, 32'h0001_0003, 32'h0000_0005, w);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 0;
    q.delete();
    seen = 0;
    @(posedge clk);
    #2;
    rst_n = 1;
    chk("midrst_result", result, 0);
    repeat (40) begin
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 0);
    end
    @(posedge clk);
    #2;
`else
    send(10, 32'h0001_0003, 32'h0000_0005, w);
    chk("mul_off_result", result, 0);
    chk("mul_off_err", err, 1);
`endif
    bp_mode = 1;
    repeat (300) begin
      op = 4'($urandom_range(0, 15));
      x = $urandom_range(0, 3) == 0 ? edges[$urandom_range(0, 3)] : $urandom();
      y = $urandom_range(0, 3) == 0 ? edges[$urandom_range(0, 3)] : $urandom();
      send(op, x, y, w);
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(posedge clk);
        #2;
      end
    end
    bp_mode = 0;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
